muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; legal WIDTH >= 4, even.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-low reset; asserted when 0.
REQ-004 SHALL have port: start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port: sign  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port: a  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port: b  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port: hilo_we  input  2  direct write enable; bit1 = HI, bit0 = LO.
REQ-010 SHALL have port: hilo_wd  input  WIDTH  direct write data.
REQ-011 SHALL have port: lohi  input  1  result select; 1 = HI, 0 = LO.
REQ-012 SHALL have port: result  output  WIDTH  combinational lohi ? HI : LO.
REQ-013 SHALL have port: hi  output  WIDTH  HI register.
REQ-014 SHALL have port: lo  output  WIDTH  LO register.
REQ-015 SHALL have port: busy  output  1  operation in progress.
REQ-016 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port: div_by_zero  output  1  pulses with done when divisor was 0.

Function
REQ-018 SHALL use states IDLE, RUN, FIX; IDLE->RUN on start (op legal), RUN->FIX after WIDTH iterations, FIX->IDLE unconditionally.
REQ-019 SHALL latch a, b, op, sign at the start edge; later input changes have no effect.
REQ-020 SHALL iterate one bit per cycle (shift-add multiply, restoring divide) on operand magnitudes, with a log2(WIDTH)+1-bit counter.
REQ-021 SHALL, for start sampled at edge k, hold busy=1 in cycles k+1..k+WIDTH and done=1, busy=0 only in cycle k+WIDTH+1.
REQ-022 SHALL apply sign correction in FIX and make new HI/LO visible in the done cycle.
REQ-023 SHALL accept a new start in the done cycle (back-to-back, no bubble).
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, for multiply, set {HI,LO} = full 2*WIDTH-bit product, signed or unsigned per sign.
REQ-026 SHALL, for divide, set LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-027 SHALL, for divisor 0, set LO = all ones, HI = a, and pulse div_by_zero with done at normal latency.
REQ-028 SHALL, for signed MIN / -1, set LO = MIN and HI = 0 with no flag.
REQ-029 SHALL perform hilo_we writes at the next edge only when IDLE and start is low; drop them while busy or when start is high in the same cycle.

Reset
REQ-030 SHALL, while rst=0, force IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-031 SHALL abort any in-flight operation on reset, with no done pulse and no HI/LO update after release.
REQ-032 SHALL treat the first rising clk after rst returns to 1 as a normal IDLE cycle.

Configuration
REQ-033 SHALL, with MULDIV_DIV_EN defined, implement divide per REQ-026..028.
REQ-034 SHALL, with MULDIV_DIV_EN undefined, ignore start with op=1 (stay IDLE, no busy, no done, HI/LO unchanged), tie div_by_zero to 0, and omit the divider logic.

Verification (WIDTH=32, MULDIV_DIV_EN defined unless stated)
REQ-035 SHALL cover: unsigned mult 0xFFFFFFFF*0xFFFFFFFF, start at edge k -> done only at cycle k+33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 SHALL cover: signed mult -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; lohi=1 -> result=0xFFFFFFFF.
REQ-037 SHALL cover: signed div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 SHALL cover: div 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, div_by_zero=1 for exactly the done cycle.
REQ-039 SHALL cover: start and hilo_we=2'b11 pulsed mid-operation -> both ignored; rst low at cycle k+10 -> HI=LO=0, busy=0, no done pulse.
REQ-040 SHALL cover: MULDIV_DIV_EN undefined, start with op=1 -> busy stays 0, done never pulses, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
//
// Multiply is shift-add and divide is restoring division. Both work on
// operand magnitudes, one bit per clock, and apply the sign correction on
// the way into HI/LO.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// a start with op=1 is ignored and div_by_zero is tied low.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   start        request an operation (sampled only in IDLE)
//   op           0 = multiply, 1 = divide
//   sign         1 = two's-complement operands, 0 = unsigned
//   a, b         multiplicand/dividend, multiplier/divisor
//   hilo_we      direct write enable (bit1 = HI, bit0 = LO), IDLE only
//   hilo_wd      direct write data
//   lohi         result select (1 = HI, 0 = LO)
//   result       combinational lohi ? hi : lo
//   hi, lo       result registers
//   busy         operation in progress
//   done         one-cycle completion pulse, new HI/LO visible with it
//   div_by_zero  pulses with done when the divisor was zero
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wd,
    input  logic             lohi,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;      // running product high half / partial remainder
    logic [WIDTH-1:0]   mq;       // multiplier / dividend, shifted out as the result grows
    logic [WIDTH-1:0]   md;       // multiplicand / divisor magnitude
    logic               neg_q;    // product / quotient must be negated

    logic               accept;
    logic               busy_c;
    logic               finish;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   acc_step, mq_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

`ifdef MULDIV_DIV_EN
    logic               op_q;
    logic               rneg_q;   // remainder takes the dividend's sign
    logic               dz_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               q_bit;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    always_comb begin
        a_neg = sign & a[WIDTH-1];
        b_neg = sign & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
`ifdef MULDIV_DIV_EN
        accept = (state == IDLE) & start;
`else
        accept = (state == IDLE) & start & ~op;
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // RUN performs WIDTH-1 iterations; the final iteration happens on the
    // FIX edge together with the sign correction, so the corrected result
    // lands in HI/LO exactly as done rises.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == CW'(WIDTH - 2)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_c = (state == RUN) || (state == FIX);
        finish = (state == FIX);
    end

    assign busy   = busy_c;
    assign result = lohi ? hi : lo;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, md} : '0);
        acc_step = mul_sum[WIDTH:1];
        mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Restoring step; the subtract is kept WIDTH bits wide because when
        // it is taken the true difference is below the divisor.
        rem_sh  = {acc, mq[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - md;
        q_bit   = (rem_sh >= {1'b0, md});
        if (op_q) begin
            acc_step = q_bit ? rem_sub : rem_sh[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], q_bit};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Sign correction of the final iteration
    // ------------------------------------------------------------------
    always_comb begin
        prod     = {acc_step, mq_step};
        prod_fix = neg_q ? -prod : prod;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        // A zero divisor naturally yields an all-ones quotient and |a| as
        // remainder; with the quotient left unnegated and the remainder
        // given the dividend's sign, HI reproduces a exactly.
        if (op_q) begin
            lo_fix = neg_q  ? -mq_step  : mq_step;
            hi_fix = rneg_q ? -acc_step : acc_step;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            md    <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= finish;

            if (accept) begin
                cnt   <= '0;
                acc   <= '0;
                mq    <= op ? a_mag : b_mag;
                md    <= op ? b_mag : a_mag;
                neg_q <= (a_neg ^ b_neg) & ~(op & (b == '0));
            end else if (busy_c) begin
                cnt <= cnt + CW'(1);
                acc <= acc_step;
                mq  <= mq_step;
            end

            if (finish) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end else if ((state == IDLE) && !start) begin
                if (hilo_we[1]) hi <= hilo_wd;
                if (hilo_we[0]) lo <= hilo_wd;
            end
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= finish & dz_q;
            if (accept) begin
                op_q   <= op;
                rneg_q <= op & a_neg;
                dz_q   <= op & (b == '0);
            end
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH = 32). Expected HI/LO values
// come from a 64-bit arithmetic model pushed into a scoreboard at issue time
// and popped when the unit signals done. Divide scenarios are built when
// MULDIV_DIV_EN is defined; otherwise the ignored-divide behaviour is checked.
module tb_muldiv_unit;

    localparam int W = 32;

`ifdef MULDIV_DIV_EN
    localparam logic HAS_DIV = 1'b1;
`else
    localparam logic HAS_DIV = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   hilo_we;
    logic [W-1:0] hilo_wd;
    logic         lohi;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] hi0;
    logic [W-1:0] lo0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .sign        (sign),
        .a           (a),
        .b           (b),
        .hilo_we     (hilo_we),
        .hilo_wd     (hilo_wd),
        .lohi        (lohi),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic o, input logic s,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx, sy, q, r;
        e.dz = 1'b0;
        if (!o) begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = sx * sy;
            end else begin
                p = {32'd0, x} * {32'd0, y};
            end
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == '0) begin
            e.lo = '1;
            e.hi = x;
            e.dz = 1'b1;
        end else if (s) begin
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            q    = sx / sy;
            r    = sx % sy;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    // Drive a start request (takes effect at the next rising edge).
    task automatic go(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        sign  = s;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(o, s, x, y));
    endtask

    // Follow one operation from its start edge to the done cycle. Returns
    // at the falling edge of the done cycle. poke_at >= 0 pulses start and
    // hilo_we for one cycle at that busy cycle.
    task automatic track(input string name, input int poke_at);
        int   done_at;
        int   pulses;
        int   bad;
        exp_t e;
        done_at = -1;
        pulses  = 0;
        bad     = 0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        hilo_we = 2'b00;
        a       = $urandom;
        b       = $urandom;
        sign    = ~sign;
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = j;
            end
            if (j == 0) begin
                hi0 = hi;
                lo0 = lo;
            end
            if (j < W) begin
                if (busy !== 1'b1 || div_by_zero !== 1'b0 || hi !== hi0 || lo !== lo0) bad++;
            end else if (busy !== 1'b0) begin
                bad++;
            end
            if (j == poke_at) begin
                start   = 1'b1;
                op      = 1'b0;
                a       = $urandom;
                b       = $urandom;
                hilo_we = 2'b11;
                hilo_wd = $urandom;
            end
            if (j == poke_at + 1) begin
                start   = 1'b0;
                hilo_we = 2'b00;
            end
        end
        checks++;
        if (done_at != W || pulses != 1) begin
            errors++;
            $display("FAIL %s latency: done first at cycle %0d with %0d pulses, expected cycle %0d with 1 pulse",
                     name, done_at, pulses, W);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s busy_window: %0d bad cycles (busy/flag/hilo), expected 0", name, bad);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: empty queue, expected an entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (hi !== e.hi) begin
                errors++;
                $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
            end
            checks++;
            if (lo !== e.lo) begin
                errors++;
                $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
            end
            checks++;
            if (div_by_zero !== e.dz) begin
                errors++;
                $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, e.dz);
            end
            lohi = 1'b0;
            #1;
            checks++;
            if (result !== e.lo) begin
                errors++;
                $display("FAIL %s result_lo: got %h expected %h", name, result, e.lo);
            end
            lohi = 1'b1;
            #1;
            checks++;
            if (result !== e.hi) begin
                errors++;
                $display("FAIL %s result_hi: got %h expected %h", name, result, e.hi);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, div_by_zero);
        end
        rst = 1'b1;
    endtask

    task automatic test_hilo_write;
        @(negedge clk);
        hilo_we = 2'b10;
        hilo_wd = 32'h1111_2222;
        @(negedge clk);
        hilo_we = 2'b01;
        hilo_wd = 32'h3333_4444;
        checks++;
        if (hi !== 32'h1111_2222 || lo !== '0) begin
            errors++;
            $display("FAIL hilo_write_hi: got hi=%h lo=%h expected 11112222 00000000", hi, lo);
        end
        @(negedge clk);
        hilo_we = 2'b00;
        checks++;
        if (hi !== 32'h1111_2222 || lo !== 32'h3333_4444) begin
            errors++;
            $display("FAIL hilo_write_lo: got hi=%h lo=%h expected 11112222 33334444", hi, lo);
        end
        // write requested in the same cycle as start must be dropped
        hilo_we = 2'b11;
        hilo_wd = 32'hDEAD_BEEF;
        go(1'b0, 1'b0, 32'd0, 32'd0);
        track("hilo_drop", -1);
        checks++;
        if (hi0 !== 32'h1111_2222 || lo0 !== 32'h3333_4444) begin
            errors++;
            $display("FAIL hilo_drop_on_start: got hi=%h lo=%h expected 11112222 33334444", hi0, lo0);
        end
        @(negedge clk);
    endtask

    task automatic test_mult;
        go(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track("mul_max", -1);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_max_after: got done=%b busy=%b expected 0 0", done, busy);
        end
        go(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        track("mul_neg3x5", -1);
        @(negedge clk);
        go(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
        track("mul_min_min", -1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            go(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            track("mul_rand", -1);
            @(negedge clk);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        go(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        track("div_neg7_2", -1);
        @(negedge clk);
        go(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        track("div_min_neg1", -1);
        @(negedge clk);
        go(1'b1, 1'b0, 32'h0000_1234, 32'd0);
        track("div_zero_u", -1);
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_pulse: got div_by_zero=%b after done cycle expected 0", div_by_zero);
        end
        go(1'b1, 1'b1, 32'hFFFF_FF00, 32'd0);
        track("div_zero_s", -1);
        @(negedge clk);
        go(1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9);
        track("div_pos_neg", -1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            go(1'b1, 1'($urandom_range(0, 1)), $urandom, (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom);
            track("div_rand", -1);
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_back_to_back;
        go(1'b0, 1'b0, 32'd123456, 32'd7890);
        track("b2b_first", -1);
        go(HAS_DIV, 1'b1, 32'hFFFF_0000, 32'd3);
        track("b2b_second", -1);
        go(1'b0, 1'b1, $urandom, $urandom);
        track("b2b_third", -1);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_busy_ignore;
        go(1'b0, 1'b1, 32'h0001_2345, 32'hFFFE_0001);
        track("busy_ignore", 5);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_after: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort;
        int bad;
        @(negedge clk);
        hilo_we = 2'b11;
        hilo_wd = 32'hA5A5_A5A5;
        @(negedge clk);
        hilo_we = 2'b00;
        go(1'b0, 1'b0, 32'h1234, 32'h5678);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL abort_hilo: got hi=%h lo=%h expected 0 0", hi, lo);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got busy=%b done=%b dz=%b expected 0 0 0", busy, done, div_by_zero);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d cycles with activity after release, expected 0", bad);
        end
    endtask

`ifndef MULDIV_DIV_EN
    task automatic test_div_disabled;
        int bad;
        @(negedge clk);
        hilo_we = 2'b11;
        hilo_wd = 32'h5A5A_0F0F;
        @(negedge clk);
        hilo_we = 2'b00;
        op    = 1'b1;
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
                hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_disabled: %0d cycles with activity or changed hilo, expected 0", bad);
        end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        sign    = 1'b0;
        a       = '0;
        b       = '0;
        hilo_we = 2'b00;
        hilo_wd = '0;
        lohi    = 1'b0;

        test_reset();
        test_hilo_write();
        test_mult();
`ifdef MULDIV_DIV_EN
        test_div();
`endif
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
`ifndef MULDIV_DIV_EN
        test_div_disabled();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
